// File: rtl/i2c_eeprom_rw.sv
// Single-master I2C controller for 24Cxx-style EEPROMs: one-byte write and
// one-byte random read, open-drain SDA, push-pull SCL, no clock stretching.
module i2c_eeprom_rw #(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int            CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEVW, S_ACK1, S_WADDR, S_ACK2, S_WDATA, S_ACK3,
    S_RSTART, S_DEVR, S_ACK4, S_RDATA, S_MNACK, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          op_rd_q, op_rd_d;
  logic          samp_q, samp_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          scl_q, scl_d;
  logic          sda_low_q, sda_low_d;
  logic          tick_s, bit_end_s;
  logic [7:0]    tx_bits_s;

  // Byte the master shifts out in a given transmit state; MNACK sends all ones.
  function automatic logic [7:0] tx_byte(input state_t s, input logic [7:0] a,
                                         input logic [7:0] d);
    case (s)
      S_DEVW:  tx_byte = {DEV_ADDR, 1'b0};
      S_WADDR: tx_byte = a;
      S_WDATA: tx_byte = d;
      S_DEVR:  tx_byte = {DEV_ADDR, 1'b1};
      default: tx_byte = 8'hFF;
    endcase
  endfunction

  // Sequencing: request accept, quarter/bit timing, ACK and read-data sampling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_rd_d   = op_rd_q;
    samp_d    = samp_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    tick_s    = (cnt_q == CNT_MAX);
    bit_end_s = tick_s && (qtr_q == 2'd3);

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      qtr_d = 2'd0;
      bit_d = 3'd0;
      if (wr_req || rd_req) begin
        state_d   = S_START;
        addr_d    = addr;
        wdata_d   = wr_data;
        op_rd_d   = ~wr_req;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
      end else begin
        busy_d = 1'b0;
      end
    end else begin
      cnt_d = tick_s ? '0 : (cnt_q + CNT_ONE);
      qtr_d = tick_s ? (qtr_q + 2'd1) : qtr_q;
      // Entry into q2 is mid-high: the slave's bit is stable here.
      if (tick_s && (qtr_q == 2'd1)) begin
        samp_d = sda;
        rx_d   = (state_q == S_RDATA) ? {rx_q[6:0], sda} : rx_q;
      end else begin
        samp_d = samp_q;
      end

      if (bit_end_s) begin
        case (state_q)
          S_START:  begin state_d = S_DEVW; bit_d = 3'd0; end
          S_RSTART: begin state_d = S_DEVR; bit_d = 3'd0; end
          S_DEVW, S_WADDR, S_WDATA, S_DEVR, S_RDATA: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              case (state_q)
                S_DEVW:  state_d = S_ACK1;
                S_WADDR: state_d = S_ACK2;
                S_WDATA: state_d = S_ACK3;
                S_DEVR:  state_d = S_ACK4;
                default: state_d = S_MNACK;
              endcase
            end else begin
              state_d = state_q;
            end
          end
          S_ACK1, S_ACK2, S_ACK3, S_ACK4: begin
            bit_d = 3'd0;
            if (samp_q) begin
              state_d   = S_STOP;
              ack_err_d = 1'b1;
            end else begin
              case (state_q)
                S_ACK1:  state_d = S_WADDR;
                S_ACK2:  state_d = op_rd_q ? S_RSTART : S_WDATA;
                S_ACK3:  state_d = S_STOP;
                default: state_d = S_RDATA;
              endcase
            end
          end
          S_MNACK: state_d = S_STOP;
          S_STOP: begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rd_data_d = (op_rd_q && !ack_err_q) ? rx_q : rd_data_q;
          end
          default: state_d = S_IDLE;
        endcase
      end else begin
        state_d = state_q;
      end
    end
  end

  // Bus levels for the upcoming state/quarter, registered so the pins never glitch.
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    tx_bits_s = tx_byte(state_d, addr_d, wdata_d);
    case (state_d)
      S_IDLE: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
      S_START, S_RSTART: begin
        scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_low_d = qtr_d[1];
      end
      S_STOP: begin
        scl_d     = (qtr_d != 2'd0);
        sda_low_d = ~qtr_d[1];
      end
      S_ACK1, S_ACK2, S_ACK3, S_ACK4, S_RDATA: begin
        scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_low_d = 1'b0;
      end
      default: begin
        scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_low_d = ~tx_bits_s[3'd7 - bit_d];
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      op_rd_q   <= 1'b0;
      samp_q    <= 1'b0;
      rx_q      <= 8'h00;
      rd_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_rd_q   <= op_rd_d;
      samp_q    <= samp_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign scl     = scl_q;
  assign sda     = sda_low_q ? 1'b0 : 1'bz;
  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_eeprom_rw.sv
// Directed bench for i2c_eeprom_rw with a behavioural 24Cxx slave on the bus.
module tb_i2c_eeprom_rw;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_req, rd_req;
  logic [7:0] addr, wr_data;
  logic [7:0] rd_data;
  logic       busy, done, ack_err, scl;
  wire        sda;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  i2c_eeprom_rw #(.CLK_DIV(3), .DEV_ADDR(7'b1010000)) dut (
    .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .rd_req(rd_req),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  // EEPROM model: open-drain driver plus pull-up
  logic       sda_lo = 1'b0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] log_q [$];
  int         starts = 0;
  int         bitn = 0;
  int         phase = 0;       // 0 dev, 1 addr, 2 data, 3 slave sending, 4 finished
  logic       active = 1'b0;
  logic       tx_pending = 1'b0;
  logic       mack = 1'b0;
  logic       nack_dev = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic [7:0] sh = 8'h00;
  logic [7:0] ptr = 8'h00;
  logic [7:0] txb = 8'h00;

  assign sda = sda_lo ? 1'b0 : 1'bz;
  pullup (sda);

  always @(sda or scl) begin
    if (scl === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
      active = 1'b1; bitn = -1; phase = 0; sda_lo = 1'b0; starts = starts + 1;
    end else if (scl === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b0 && sda === 1'b1) begin
      active = 1'b0; sda_lo = 1'b0;
    end else if (active && prev_scl === 1'b0 && scl === 1'b1) begin
      if (phase == 3) begin
        if (bitn == 8) mack = sda;
      end else if (bitn >= 0 && bitn < 8) begin
        sh = {sh[6:0], sda};
      end
    end else if (active && prev_scl === 1'b1 && scl === 1'b0) begin
      if (bitn == -1) begin
        bitn = 0;
      end else if (bitn < 8) begin
        bitn = bitn + 1;
        if (phase == 3) begin
          sda_lo = (bitn < 8) ? ~txb[7 - bitn] : 1'b0;
        end else if (bitn == 8) begin
          log_q.push_back(sh);
          case (phase)
            0: begin
              if (sh[7:1] == 7'h50 && !nack_dev) begin
                sda_lo = 1'b1;
                phase = sh[0] ? 3 : 1;
                tx_pending = sh[0];
              end else begin
                sda_lo = 1'b0;
              end
            end
            1: begin ptr = sh; sda_lo = 1'b1; phase = 2; end
            default: begin mem[ptr] = sh; ptr = ptr + 8'd1; sda_lo = 1'b1; end
          endcase
        end
      end else begin
        bitn = 0; sda_lo = 1'b0;
        if (phase == 3) begin
          if (tx_pending || !mack) begin
            if (!tx_pending) ptr = ptr + 8'd1;
            tx_pending = 1'b0;
            txb = mem[ptr];
            sda_lo = ~txb[7];
          end else begin
            phase = 4;
          end
        end
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  int base_log = 0;
  int base_starts = 0;
  int lat = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_txn(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    wr_req = w; rd_req = r; addr = a; wr_data = d;
    base_log = log_q.size();
    base_starts = starts;
    @(posedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); n++; #1;
      if (done) break;
    end
  endtask

  task automatic chk_bytes(input string tag, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp [3];
    logic [31:0] got;
    exp[0] = b0; exp[1] = b1; exp[2] = b2;
    chk({tag, "_nbytes"}, log_q.size() - base_log, n);
    for (int i = 0; i < n; i++) begin
      got = (base_log + i < log_q.size()) ? {24'h0, log_q[base_log + i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", tag, i), got, {24'h0, exp[i]});
    end
  endtask

  initial begin
    reset_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; addr = 8'h00; wr_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ackerr", ack_err, 1'b0);
    chk("rst_rddata", rd_data, 8'h00);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // single-byte write
    start_txn(1'b1, 1'b0, 8'h05, 8'h1F);
    chk("wr_busy", busy, 1'b1);
    wait_done(lat);
    chk("wr_latency", lat, 348);
    chk("wr_busy_at_done", busy, 1'b0);
    chk("wr_ackerr", ack_err, 1'b0);
    chk("wr_mem5", mem[5], 8'h1F);
    chk("wr_starts", starts - base_starts, 1);
    chk_bytes("wr", 3, 8'hA0, 8'h05, 8'h1F);
    @(posedge clk); #1;
    chk("wr_done_one_clk", done, 1'b0);

    // random read back
    start_txn(1'b0, 1'b1, 8'h05, 8'h00);
    wait_done(lat);
    chk("rd_latency", lat, 468);
    chk("rd_data", rd_data, 8'h1F);
    chk("rd_ackerr", ack_err, 1'b0);
    chk("rd_starts", starts - base_starts, 2);
    chk("rd_master_nack", mack, 1'b1);
    chk_bytes("rd", 3, 8'hA0, 8'h05, 8'hA1);

    // device address NACK
    nack_dev = 1'b1;
    start_txn(1'b0, 1'b1, 8'h05, 8'h00);
    wait_done(lat);
    chk("nack_latency", lat, 132);
    chk("nack_ackerr", ack_err, 1'b1);
    chk("nack_rddata_held", rd_data, 8'h1F);
    chk_bytes("nack", 1, 8'hA0, 8'h00, 8'h00);
    nack_dev = 1'b0;
    @(posedge clk); #1;

    // both requests: write wins, held read follows after done
    start_txn(1'b1, 1'b1, 8'h10, 8'hAA);
    rd_req = 1'b1;
    wait_done(lat);
    chk("both_wr_latency", lat, 348);
    chk("both_ackerr", ack_err, 1'b0);
    chk("both_mem16", mem[16], 8'hAA);
    chk_bytes("both_wr", 3, 8'hA0, 8'h10, 8'hAA);
    base_log = log_q.size();
    base_starts = starts;
    @(posedge clk); #1;
    rd_req = 1'b0;
    chk("both_rd_accept", busy, 1'b1);
    wait_done(lat);
    chk("both_rd_latency", lat, 468);
    chk("both_rd_data", rd_data, 8'hAA);
    chk_bytes("both_rd", 3, 8'hA0, 8'h10, 8'hA1);
    @(posedge clk); #1;

    // request while busy is ignored
    start_txn(1'b1, 1'b0, 8'h20, 8'h5C);
    repeat (50) @(posedge clk);
    #1; rd_req = 1'b1; addr = 8'h33; wr_data = 8'hFF;
    repeat (5) @(posedge clk);
    #1; rd_req = 1'b0;
    wait_done(lat);
    chk("busy_req_latency", lat, 348 - 55);
    chk("busy_req_mem20", mem[8'h20], 8'h5C);
    chk("busy_req_mem33", mem[8'h33], 8'h00);
    chk_bytes("busy_req", 3, 8'hA0, 8'h20, 8'h5C);
    @(posedge clk); #1;
    chk("busy_req_no_restart", busy, 1'b0);

    // reset during WADDR, then a clean write
    start_txn(1'b1, 1'b0, 8'h40, 8'h99);
    repeat (160) @(posedge clk);
    #2; reset_n = 1'b0;
    #1;
    chk("midrst_scl", scl, 1'b1);
    chk("midrst_sda", sda, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("midrst_idle", busy, 1'b0);
    start_txn(1'b1, 1'b0, 8'h41, 8'h77);
    wait_done(lat);
    chk("post_rst_latency", lat, 348);
    chk("post_rst_mem41", mem[8'h41], 8'h77);
    chk("post_rst_mem40", mem[8'h40], 8'h00);
    chk_bytes("post_rst", 3, 8'hA0, 8'h41, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_rw.md
# i2c_eeprom_rw

I2C master that performs single-byte write and single-byte random-read transactions on a 24Cxx-style EEPROM (8-bit word address). It sits between the control logic and the seven-segment display driver. Its `rd_data` output is the byte that the display stage receives on its `data` input. Only standard-mode single-master operation is supported: no clock stretching and no arbitration.

## Interface
- `CLK_DIV`, 125 — system clocks per quarter SCL period (125 @ 50 MHz gives 100 kHz SCL); legal range is ≥2.
- `DEV_ADDR`, 7'b1010000 — 7-bit EEPROM device address.

Ports:
- `clk` input 1 — single system clock; all logic runs on its rising edge.
- `reset_n` input 1 — reset, asynchronous, active-low.
- `wr_req` input 1 — request a byte write; level, sampled only in IDLE.
- `rd_req` input 1 — request a random read; level, sampled only in IDLE.
- `addr` input 8 — EEPROM word address, latched on accept.
- `wr_data` input 8 — write byte, latched on accept.
- `rd_data` output 8 — last successfully read byte; feeds the display stage.
- `busy` output 1 — transaction in progress.
- `done` output 1 — one-clock pulse at transaction end.
- `ack_err` output 1 — last transaction saw a NACK.
- `scl` output 1 — I2C clock, push-pull.
- `sda` inout 1 — open-drain: driven 0 or released to `z`; the board provides the pull-up.

## Operation
- **Quarter tick:** a counter counts 0..CLK_DIV-1 and runs only while not IDLE. Each wrap advances a 2-bit quarter index q0..q3. One bit period is 4·CLK_DIV clocks.
- **Data bit (master-driven):**
  - q0: SCL=0, SDA set to the bit value.
  - q1 and q2: SCL=1.
  - q3: SCL=0.
  - Bits are sent MSB first.
- **Receive bit (ACK or read data):**
  - SDA is released for all four quarters.
  - The bit is sampled on entry to q2 (mid-high).
- **START / repeated START:**
  - q0: SDA=1, SCL=0.
  - q1: SDA=1, SCL=1.
  - q2: SDA=0, SCL=1.
  - q3: SDA=0, SCL=0.
- **STOP:**
  - q0: SDA=0, SCL=0.
  - q1: SDA=0, SCL=1.
  - q2 and q3: SDA=1, SCL=1.
- **FSM states:** IDLE, START, DEVW, ACK1, WADDR, ACK2, WDATA, ACK3, RSTART, DEVR, ACK4, RDATA, MNACK, STOP.
  - Write sequence: START→DEVW ({DEV_ADDR,0})→ACK1→WADDR→ACK2→WDATA→ACK3→STOP→IDLE.
  - Read sequence: START→DEVW→ACK1→WADDR→ACK2→RSTART→DEVR ({DEV_ADDR,1})→ACK4→RDATA (8 bits)→MNACK (master drives SDA=1)→STOP→IDLE.
- **NACK:** if any slave ACK bit samples 1, go to STOP after that bit's q3 and set the error flag.
- **Accept:**
  - In IDLE with `wr_req` or `rd_req` high, latch `addr`, `wr_data` and the operation type; set `busy`; clear `ack_err`.
  - If both requests are high, the write wins. The read is not queued; it is re-sampled after `done`.
- **Ignored requests:** requests while `busy` are ignored. Input changes while `busy` do not affect the transaction in flight.
- **`rd_data`:** updated from the shift register only when a read completes with no NACK. It is held otherwise.
- **`done`:** high for exactly one clock on the cycle IDLE is re-entered. `busy` falls on the same clock. `ack_err` becomes valid on that clock and holds until the next accept.

## Timing
- **Reset values:**
  - scl=1, sda=z, busy=0, done=0, ack_err=0, rd_data=8'h00.
  - FSM is in IDLE with counters at 0.
- **Reset mid-transfer:** same as the reset values, applied immediately; no STOP is generated.
- **Write latency:** 29 bit periods = 116·CLK_DIV clocks from the accept edge to `done` (START, 27 data/ACK bits, STOP).
- **Read latency:** 39 bit periods = 156·CLK_DIV clocks (START, 18 bits, RSTART, 18 bits, STOP).
- **NACK latency:** a NACK at ACK1 gives `done` 11 bit periods after accept (START, 9 bits, STOP).
- **IDLE levels:** scl=1, sda=z.
- **Back-to-back:** the earliest next accept is the clock after `done`.

## Test plan
Use a bench EEPROM model with a 256-byte array and a pull-up, with CLK_DIV=3.
- `wr_req` with addr=8'h05, wr_data=8'h1F, slave ACKs → SDA bytes A0, 05, 1F are observed; `done` pulses 348 clocks after accept; ack_err=0; model mem[5]=8'h1F.
- `rd_req` with addr=8'h05 after the write → bytes A0, 05, repeated START, A1 are observed; master NACKs the data; rd_data=8'h1F; `done` pulses at 468 clocks.
- Model NACKs the device address → STOP follows ACK1; `done` at 132 clocks; ack_err=1; rd_data is unchanged.
- `wr_req` and `rd_req` high together with addr=8'h10, wr_data=8'hAA → write executes; mem[16]=8'hAA; no read occurs until after `done`.
- `rd_req` pulsed while busy with a different addr → ignored; the transaction in flight uses the latched addr.
- `reset_n` low during WADDR → scl=1, sda=z and busy=0 on the assertion edge; a new write completes correctly afterward.
